// File: rtl/cmp_pkg.sv
// Shared definitions for the serial compare controller: state encoding and
// the default operand width.
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int CMP_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } cmp_state_e;

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit equality/greater cell; purely combinational.
module bit_cmp_cell (
    input  logic i0,
    input  logic i1,
    output logic eq,
    output logic gr
);

    assign eq = ~(i0 ^ i1);
    assign gr = i0 & ~i1;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Walks two captured operands MSB-first through one bit_cmp_cell, stopping
// at the first differing bit, with a start/busy/done handshake.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEF,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gr
);

    cmp_state_e state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gr_q, gr_d;
    logic             cell_eq;
    logic             cell_gr;

    bit_cmp_cell u_cell (
        .i0 (sa_q[WIDTH-1]),
        .i1 (sb_q[WIDTH-1]),
        .eq (cell_eq),
        .gr (cell_gr)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gr_d    = gr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    idx_d   = CNT_W'(WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!cell_eq) begin
                    eq_d    = 1'b0;
                    gr_d    = cell_gr;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    // last bit matched too: operands are equal
                    eq_d    = 1'b1;
                    gr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    sa_d  = sa_q << 1;
                    sb_d  = sb_q << 1;
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gr_q    <= gr_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign eq   = eq_q;
    assign gr   = gr_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl: WIDTH=8 and WIDTH=1 instances,
// expected results queued at start and compared when done appears.
module tb_serial_cmp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, eq8, gr8;
    logic       start1;
    logic [0:0] a1, b1;
    logic       busy1, done1, eq1, gr1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic eq;
        logic gr;
        int   lat;
    } exp_t;
    exp_t sb[$];

    serial_cmp_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .eq(eq8), .gr(gr8)
    );

    serial_cmp_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .eq(eq1), .gr(gr1)
    );

    // Edges after acceptance until done is visible: first differing bit i gives WIDTH-i.
    function automatic int model_lat(input logic [31:0] x, input logic [31:0] y, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return w - i;
        end
        return w;
    endfunction

    task automatic push8(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e.eq  = (x == y);
        e.gr  = (x > y);
        e.lat = model_lat({24'd0, x}, {24'd0, y}, 8);
        sb.push_back(e);
    endtask

    task automatic launch8(input string name, input logic [7:0] x, input logic [7:0] y, input bit hold);
        @(negedge clk);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        push8(x, y);
        @(posedge clk);
        #1;
        if (!hold) start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy8);
        end
    endtask

    task automatic finish8(input string name);
        int   k;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done_timeout: no done within 40 edges, expected after %0d", name, e.lat);
        end else begin
            checks++;
            if (k != e.lat) begin
                failures++;
                $display("FAIL %s latency: done after E%0d expected E%0d", name, k, e.lat);
            end
            checks++;
            if (eq8 !== e.eq || gr8 !== e.gr) begin
                failures++;
                $display("FAIL %s result: eq=%b gr=%b expected eq=%b gr=%b", name, eq8, gr8, e.eq, e.gr);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b expected done=0 busy=0", name, done8, busy8);
        end
        $display("%s: a/b result eq=%b gr=%b done_at=E%0d", name, eq8, gr8, k);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, eq8, gr8, busy1, done1, eq1, gr1} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got %b expected 00000000",
                     {busy8, done8, eq8, gr8, busy1, done1, eq1, gr1});
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic test_equal();
        launch8("equal_a5", 8'hA5, 8'hA5, 1'b0);
        finish8("equal_a5");
    endtask

    task automatic test_msb_mismatch();
        launch8("msb_80_7f", 8'h80, 8'h7F, 1'b0);
        finish8("msb_80_7f");
    endtask

    task automatic test_lsb_mismatch();
        launch8("lsb_12_13", 8'h12, 8'h13, 1'b0);
        checks++;
        if (eq8 !== 1'b0 || gr8 !== 1'b1) begin
            failures++;
            $display("FAIL lsb_12_13 held_during_run: eq=%b gr=%b expected eq=0 gr=1", eq8, gr8);
        end
        finish8("lsb_12_13");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (eq8 !== 1'b0 || gr8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL lsb_12_13 held_idle: eq=%b gr=%b done=%b expected 0 0 0", eq8, gr8, done8);
        end
    endtask

    task automatic test_back_to_back();
        launch8("capture_03_01", 8'h03, 8'h01, 1'b1);
        @(negedge clk);
        a8 = 8'h00;
        b8 = 8'hFF;
        finish8("capture_03_01");
        // start still high: accepted at the edge after the idle cycle
        push8(a8, b8);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back accept: busy=%b expected 1", busy8);
        end
        finish8("b2b_00_ff");
    endtask

    task automatic test_abort();
        int dones;
        launch8("pre_abort_05_03", 8'h05, 8'h03, 1'b0);
        finish8("pre_abort_05_03");
        launch8("abort_ff_ff", 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, eq8, gr8} !== 4'b0000) begin
            failures++;
            $display("FAIL abort async_clear: busy/done/eq/gr=%b expected 0000", {busy8, done8, eq8, gr8});
        end
        void'(sb.pop_front());
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1 || busy8 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort no_done: %0d busy/done cycles seen expected 0", dones);
        end
        $display("abort: reset mid-run cleared outputs");
        launch8("post_abort_01_02", 8'h01, 8'h02, 1'b0);
        finish8("post_abort_01_02");
    endtask

    task automatic test_width1();
        logic [1:0] vec [2];
        vec[0] = 2'b10;
        vec[1] = 2'b11;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            a1 = vec[t][1];
            b1 = vec[t][0];
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                failures++;
                $display("FAIL w1_%0d run: busy=%b done=%b expected 1 0", t, busy1, done1);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done1 !== 1'b1 || eq1 !== (a1 == b1) || gr1 !== (a1 > b1)) begin
                failures++;
                $display("FAIL w1_%0d result: done=%b eq=%b gr=%b expected 1 %b %b",
                         t, done1, eq1, gr1, (a1 == b1), (a1 > b1));
            end
            @(posedge clk);
            #1;
            checks++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                failures++;
                $display("FAIL w1_%0d idle: done=%b busy=%b expected 0 0", t, done1, busy1);
            end
            $display("width1 a=%b b=%b eq=%b gr=%b", a1, b1, eq1, gr1);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_mismatch();
        test_lsb_mismatch();
        test_back_to_back();
        test_abort();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
Sequencing controller for the 1-bit equality/greater cell of the Mini ALU. It accepts two WIDTH-bit unsigned operands on a start pulse and walks them MSB-first through a single bit-compare cell, one bit per clock. It stops at the first differing bit and reports eq/gr with a start/busy/done handshake. It sits between the ALU operand registers and the ALU result mux.

Parameters:
WIDTH, 8, operand width in bits; legal range 1 to 32.
CNT_W, $clog2(WIDTH) (minimum 1), bit-index counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a compare; sampled only in IDLE.
a  input  WIDTH  operand A, unsigned; captured on start acceptance.
b  input  WIDTH  operand B, unsigned; captured on start acceptance.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; eq/gr are valid in this cycle.
eq  output  1  1 when captured a == b; held until the next result.
gr  output  1  1 when captured a > b (unsigned); held until the next result.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. Reset forces state=IDLE, busy=0, done=0, eq=0, gr=0, and clears the shift registers and counter.
- FSM states: IDLE, RUN, DONE. busy and done are Moore outputs: busy = (state != IDLE), done = (state == DONE).
- IDLE:
  - start=1 at edge E0: load sa<=a, sb<=b, idx<=WIDTH-1, state<=RUN.
  - start=0: stay in IDLE.
- RUN, each edge: the bit cell compares sa[MSB] and sb[MSB].
  - Bits differ: eq<=0, gr<=sa[MSB], state<=DONE.
  - Bits equal and idx==0: eq<=1, gr<=0, state<=DONE.
  - Otherwise: shift sa and sb left by 1, idx<=idx-1, stay in RUN.
- DONE: lasts exactly one cycle, then state<=IDLE unconditionally.
- Latency:
  - First mismatch at bit i: the decision is made at edge E(WIDTH-i), and done is high in the following cycle.
  - Equal operands: the decision is made at edge E(WIDTH), and done is high in the following cycle.
  - Worst case, accept to IDLE: WIDTH+1 edges.
- Handshake:
  - start is ignored while busy=1, including during DONE.
  - a and b may change freely after acceptance; only the captured values matter.
  - start=1 in the cycle after DONE (state back in IDLE) is accepted, so back-to-back operation has one idle cycle.
- eq and gr are never both 1. They keep their previous values during RUN and change only on the transition into DONE.
- Reset asserted during RUN or DONE aborts the operation immediately: no done pulse, and eq/gr return to 0.
- WIDTH=1: RUN lasts exactly one edge.
- The idx counter never underflows; the transition on idx==0 takes priority over shifting.

Decomposition:
- Shared package cmp_pkg:
  - state encoding localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - default width constant CMP_WIDTH_DEF=8.
- Sub-module bit_cmp_cell: purely combinational. Inputs i0 and i1. Outputs eq = i0 XNOR i1 and gr = i0 & ~i1. The controller instantiates it once, driven by sa[MSB] and sb[MSB].

Test Plan:
1. WIDTH=8, a=8'hA5, b=8'hA5, start at E0 -> busy high after E0; done high for exactly one cycle after E8; eq=1, gr=0; busy low after E9.
2. a=8'h80, b=8'h7F -> mismatch at bit 7; done high after E1; eq=0, gr=1.
3. a=8'h12, b=8'h13 -> mismatch at bit 0; done high after E8; eq=0, gr=0; results held until the next done.
4. Start a=8'h03, b=8'h01, then hold start=1 while driving a=8'h00, b=8'hFF during RUN -> only one done; result gr=1, eq=0 (captured values used). Start=1 in the cycle after DONE is accepted.
5. a=8'hFF, b=8'hFF with reset pulsed between E3 and E4 -> busy, done, eq and gr drop to 0 asynchronously and no done pulse occurs; after reset release, a=8'h01, b=8'h02 compares to eq=0, gr=0 with done after E7.
6. WIDTH=1 instance: a=1, b=0 -> done after E1, gr=1, eq=0; then a=1, b=1 -> done after E1, eq=1, gr=0.
